// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared widths, PC increment and the FIFO entry type for the instruction
// fetch front end (if_prefetch_unit and its if_fifo).
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// ---------------------------------------------------------------------------
// if_fifo
// Synchronous FIFO of fetch entries with flush.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   flush           empties the FIFO; beats push and pop in the same cycle
//   push, push_data write one entry (taken when not full, or when popping)
//   pop             remove the head entry (ignored when empty)
//   head            current head entry (only meaningful when !empty)
//   empty           no entries held
//   count           number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module if_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         full;
  logic         do_push;
  logic         do_pop;
  fetch_entry_t mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push && reset) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
// Instruction fetch front end feeding decode. Issues sequential word fetches
// over a valid/ready request channel, collects in-order responses into a
// prefetch FIFO and presents {instr, pc, pc+4} to decode under stall_d.
// A redirect flushes buffered entries and marks in-flight fetches for drop.
// Optional build macro: IFETCH_PERF_CNT_EN adds perf_fetch_cnt,
// perf_drop_cnt and perf_starve_cnt outputs.
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   imem_req_valid/ready/addr          fetch request channel
//   imem_rsp_valid/data                in-order fetch responses, never stalled
//   redirect_valid, redirect_pc        branch/jump redirect from decode
//   stall_d                            decode stall, holds the head entry
//   instr_valid_d, instr_d, pc_d,
//   pc_plus4_d                         head entry to decode (0 when invalid)
// ---------------------------------------------------------------------------
module if_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall_d,
  output logic               instr_valid_d,
  output logic [INSTR_W-1:0] instr_d,
  output logic [ADDR_W-1:0]  pc_d,
  output logic [ADDR_W-1:0]  pc_plus4_d
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_drop_cnt,
  output logic [31:0]        perf_starve_cnt
`endif
);

  // Counter width covers occupancy plus outstanding without overflow.
  localparam int CW = $clog2(DEPTH + 1) + 1;

  logic [ADDR_W-1:0]      fetch_pc;
  logic [ADDR_W-1:0]      rsp_pc;
  logic [ADDR_W-1:0]      target_pc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          outstanding_next;
  logic [CW-1:0]          drop_cnt;
  logic [CW-1:0]          live_slots;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   req_fire;
  logic                   dropping;
  fetch_entry_t           fifo_head;
  fetch_entry_t           push_entry;

  assign target_pc = redirect_pc & ~32'h3;

  // Slots already promised: buffered entries plus responses still to be kept.
  assign live_slots = CW'(fifo_count) + outstanding - drop_cnt;

  // No request while reset is held, so nothing is accepted that would be lost.
  assign imem_req_valid = reset && !redirect_valid
                          && (outstanding < CW'(MAX_OUTSTANDING))
                          && (live_slots < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign dropping   = imem_rsp_valid && (drop_cnt != '0);
  assign fifo_push  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign fifo_pop   = instr_valid_d && !stall_d;
  assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        // Everything still in flight after this edge belongs to the old path.
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + PC_INC;
        if (fifo_push) rsp_pc   <= rsp_pc + PC_INC;
        if (dropping)  drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid_d = !fifo_empty;
  assign instr_d       = instr_valid_d ? fifo_head.instr : '0;
  assign pc_d          = instr_valid_d ? fifo_head.pc : '0;
  assign pc_plus4_d    = instr_valid_d ? (fifo_head.pc + PC_INC) : '0;

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt  <= '0;
      perf_drop_cnt   <= '0;
      perf_starve_cnt <= '0;
    end else begin
      // A head entry flushed by a redirect is not delivered.
      if (fifo_pop && !redirect_valid)   perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (imem_rsp_valid && !fifo_push)  perf_drop_cnt   <= perf_drop_cnt + 32'd1;
      if (!instr_valid_d && !stall_d)    perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_unit
// Directed bench for if_prefetch_unit. A small in-order memory model returns
// instr = addr ^ KEY after a programmable latency (1 = next cycle).
// Each step() call is one clock cycle: inputs are applied after the falling
// edge, outputs are checked before the next rising edge.
// ---------------------------------------------------------------------------
module tb_if_prefetch_unit;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        instr_valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_starve_cnt;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    lat;
  int    cyc;
  int    n_cmp;
  int    n_err;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .instr_valid_d  (instr_valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_drop_cnt   (perf_drop_cnt),
    .perf_starve_cnt (perf_starve_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs and the memory response, then record a handshake.
  task automatic step(input logic rn, input logic rv, input logic [31:0] rpc, input logic st);
    @(negedge clk);
    cyc++;
    reset          = rn;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall_d        = st;
    imem_req_ready = 1'b1;
    if (!rn) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ KEY;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (imem_req_valid && imem_req_ready)
      mq.push_back('{addr: imem_req_addr, due: cyc + lat});
    if (dut.fifo_push && !dut.fifo_pop && 32'(dut.fifo_count) == 32'd4)
      chk("fifo_overflow", 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int l);
    lat = l;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; lat = 1;
    reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall_d = 1'b0;

    // Reset state and first fetches with one-cycle memory.
    do_reset(1);
    chk("rst_ivld",  32'(instr_valid_d), 32'd0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pc",    pc_d, 32'h0);
    chk("rst_pc4",   pc_plus4_d, 32'h0);
    chk("rst_req",   32'(imem_req_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("c0_req",  32'(imem_req_valid), 32'd1);
    chk("c0_addr", imem_req_addr, 32'h0);
    chk("c0_ivld", 32'(instr_valid_d), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("c1_ivld", 32'(instr_valid_d), 32'd0);
    chk("c1_addr", imem_req_addr, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("c2_ivld",  32'(instr_valid_d), 32'd1);
    chk("c2_pc",    pc_d, 32'h0);
    chk("c2_pc4",   pc_plus4_d, 32'h4);
    chk("c2_instr", instr_d, 32'h0 ^ KEY);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("c3_pc",  pc_d, 32'h4);
    chk("c3_pc4", pc_plus4_d, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("c4_pc",    pc_d, 32'h8);
    chk("c4_instr", instr_d, 32'h8 ^ KEY);

    // Stall for 10 cycles: FIFO fills to 4 and requests stop; head is held.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (i == 0) chk("stall_head0", pc_d, 32'hC);
      if (i == 3 || i == 9) chk("stall_req", 32'(imem_req_valid), 32'd0);
      if (i == 9) begin
        chk("stall_head9", pc_d, 32'hC);
        chk("stall_ivld",  32'(instr_valid_d), 32'd1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("drain_pc",    pc_d, 32'hC + 32'(4 * i));
      chk("drain_instr", instr_d, (32'hC + 32'(4 * i)) ^ KEY);
    end

    // Redirect with two requests outstanding, three-cycle memory.
    do_reset(3);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    chk("rd3_req_redir", 32'(imem_req_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd3_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("rd3_ivld_gap", 32'(instr_valid_d), 32'd0);
      if (i == 1) begin
        chk("rd3_req",   32'(imem_req_valid), 32'd1);
        chk("rd3_addr2", imem_req_addr, 32'h100);
      end
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd3_pc",    pc_d, 32'h100);
    chk("rd3_instr", instr_d, 32'h100 ^ KEY);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd3_pc2", pc_d, 32'h104);

    // Redirect together with a response and a pop.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b0);
    chk("rdp_pre_pc", pc_d, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rdp_ivld", 32'(instr_valid_d), 32'd0);
    chk("rdp_req",  32'(imem_req_valid), 32'd1);
    chk("rdp_addr", imem_req_addr, 32'h200);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rdp_ivld2", 32'(instr_valid_d), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rdp_pc",    pc_d, 32'h200);
    chk("rdp_instr", instr_d, 32'h200 ^ KEY);

    // PC wrap; low target bits must be ignored.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr2", imem_req_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc",    pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4",   pc_plus4_d, 32'h0);
    chk("wrap_instr", instr_d, 32'hFFFF_FFFC ^ KEY);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc_next",  pc_d, 32'h0);
    chk("wrap_pc4_next", pc_plus4_d, 32'h4);

    // Reset mid-stream with three buffered entries.
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst_pre_ivld", 32'(instr_valid_d), 32'd1);
    chk("mrst_pre_pc",   pc_d, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_ivld", 32'(instr_valid_d), 32'd0);
    chk("mrst_req",  32'(imem_req_valid), 32'd1);
    chk("mrst_addr", imem_req_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_ivld2", 32'(instr_valid_d), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_pc",    pc_d, 32'h0);
    chk("mrst_instr", instr_d, 32'h0 ^ KEY);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mrst_pc2", pc_d, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
